// File: rtl/d_latch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// d_latch_pkg : shared defaults for the gated D-latch block.
// Revision    : 1.0
// ============================================================================
package d_latch_pkg;

    localparam int   DEFAULT_WIDTH     = 1;
    localparam logic DEFAULT_CLR_BIT   = 1'b0;

endpackage
`default_nettype wire

// File: rtl/d_latch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// d_latch_if : bundles the gate, clear, data and output of one latch bank.
// Revision   : 1.0
// ============================================================================
interface d_latch_if
    import d_latch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             clr;
    logic [WIDTH-1:0] d;
    logic             g;
    logic [WIDTH-1:0] q;

    modport master (output clr, output d, output g, input  q);
    modport slave  (input  clr, input  d, input  g, output q);

endinterface
`default_nettype wire

// File: rtl/d_latch_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// d_latch_bit : single level-sensitive latch with asynchronous active-low clear.
// Revision    : 1.0
// ============================================================================
module d_latch_bit
    import d_latch_pkg::*;
#(
    parameter logic CLR_VALUE = DEFAULT_CLR_BIT
) (
    input  logic clr_n_i,
    input  logic d_i,
    input  logic g_i,
    output logic q_o
);

    logic q_q;

    // Intentional latch: clear dominates the gate, gate low holds the value.
    always_latch begin
        if (!clr_n_i) begin
            q_q <= CLR_VALUE;
        end else if (g_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/d_latch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// d_latch  : WIDTH-bit gated D-latch bank, one independent latch per bit.
// Revision : 1.0
// ============================================================================
module d_latch
    import d_latch_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{DEFAULT_CLR_BIT}}
) (
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             g,
    output logic [WIDTH-1:0] q
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            d_latch_bit #(
                .CLR_VALUE (CLR_VALUE[i])
            ) u_bit (
                .clr_n_i (clr),
                .d_i     (d[i]),
                .g_i     (g),
                .q_o     (q[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_d_latch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_d_latch : scoreboard bench for 1-, 8- and 4-bit (non-zero clear) latches.
// Revision   : 1.0
// ============================================================================
module tb_d_latch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    d_latch_if #(.WIDTH(1)) if1 ();
    d_latch_if #(.WIDTH(8)) if8 ();
    d_latch_if #(.WIDTH(4)) if4 ();

    d_latch #(.WIDTH(1)) dut1 (.clr(if1.clr), .d(if1.d), .g(if1.g), .q(if1.q));
    d_latch #(.WIDTH(8)) dut8 (.clr(if8.clr), .d(if8.d), .g(if8.g), .q(if8.q));
    d_latch #(.WIDTH(4), .CLR_VALUE(4'hA))
        dut4 (.clr(if4.clr), .d(if4.d), .g(if4.g), .q(if4.q));

    typedef struct {
        string       tag;
        logic [7:0]  exp;
        int unsigned sel;
    } sb_t;

    sb_t        sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       m1 = 1'b0;
    logic [7:0] m8 = 8'h00;
    logic [3:0] m4 = 4'hA;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] exp, input int unsigned sel);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        e.sel = sel;
        sb.push_back(e);
    endtask

    // Controls change first, data 1 unit later, so a falling gate never races data.
    task automatic apply(input string tag, input logic c, input logic gg, input logic [7:0] dd);
        if1.clr = c;  if8.clr = c;  if4.clr = c;
        if1.g   = gg; if8.g   = gg; if4.g   = gg;
        #1;
        if1.d = dd[0]; if8.d = dd; if4.d = dd[3:0];
        if (!c) begin
            m1 = 1'b0; m8 = 8'h00; m4 = 4'hA;
        end else if (gg) begin
            m1 = dd[0]; m8 = dd; m4 = dd[3:0];
        end
        push({tag, "_w1"}, {7'b0, m1}, 0);
        push({tag, "_w8"}, m8, 1);
        push({tag, "_w4"}, {4'b0, m4}, 2);
    endtask

    task automatic drain();
        sb_t        e;
        logic [7:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = {7'b0, if1.q};
                1:       act = if8.q;
                default: act = {4'b0, if4.q};
            endcase
            check(e.tag, act, e.exp);
        end
    endtask

    task automatic drive(input string tag, input logic c, input logic gg, input logic [7:0] dd);
        @(posedge clk);
        apply(tag, c, gg, dd);
        @(negedge clk);
        drain();
    endtask

    initial begin
        if1.clr = 1'b0; if8.clr = 1'b0; if4.clr = 1'b0;
        if1.g   = 1'b0; if8.g   = 1'b0; if4.g   = 1'b0;
        if1.d   = 1'b0; if8.d   = 8'h00; if4.d  = 4'h0;
        #1;
        push("reset_w1", 8'h00, 0);
        push("reset_w8", 8'h00, 1);
        push("reset_w4", 8'h0A, 2);
        drain();

        for (int i = 0; i < 50; i++)
            drive("clr_rand", 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));

        for (int i = 0; i < 100; i++)
            drive("transp_rand", 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));

        drive("open_ff",   1'b1, 1'b1, 8'hFF);
        drive("close_ff",  1'b1, 1'b0, 8'hFF);
        drive("hold_ff",   1'b1, 1'b0, 8'h00);

        // Short clear pulse while holding: q must clear and stay cleared.
        @(posedge clk);
        apply("pulse_low", 1'b0, 1'b0, 8'h00);
        #2;
        drain();
        #2;
        apply("pulse_rel", 1'b1, 1'b0, 8'h00);
        #1;
        drain();
        drive("after_pulse", 1'b1, 1'b0, 8'hFF);

        drive("clr_dom", 1'b0, 1'b1, 8'hFF);
        @(posedge clk);
        apply("clr_rise_g1", 1'b1, 1'b1, 8'hFF);
        drain();
        @(negedge clk);

        drive("open_a5",  1'b1, 1'b1, 8'hA5);
        drive("close_a5", 1'b1, 1'b0, 8'hA5);
        drive("hold_a5",  1'b1, 1'b0, 8'h00);
        drive("clear_a5", 1'b0, 1'b0, 8'h00);

        drive("open_5a",  1'b1, 1'b1, 8'h5A);
        drive("close_5a", 1'b1, 1'b0, 8'h5A);
        drive("hold_5a",  1'b1, 1'b0, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
